// File: rtl/axi_read_arbiter_if.sv
// AXI4-Lite read-channel bundle (AR + R). The requester side uses the master
// modport; the side that answers reads uses the slave modport.
interface axi_read_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;

  modport master (
    output arvalid, araddr, arprot, rready,
    input  arready, rvalid, rdata, rresp
  );

  modport slave (
    input  arvalid, araddr, arprot, rready,
    output arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi_read_arbiter.sv
// Two-master / one-slave AXI4-Lite read arbiter. Master 0 is the I-cache,
// master 1 the load path. One transaction in flight, round-robin on ties,
// AR registered toward memory, R routed combinationally to the owner.
module axi_read_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  axi_read_arbiter_if.slave   m0,
  axi_read_arbiter_if.slave   m1,
  axi_read_arbiter_if.master  axi,
  output logic                busy,
  output logic                grant
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                state_q;
  logic                  arvalid_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [2:0]            arprot_q;
  logic                  grant_q;
  logic                  last_grant_q;

  logic win_vld;
  logic win;
  logic in_data;

  // Winner selection: a lone requester wins, a tie goes to whoever did not
  // own the previous transaction.
  always_comb begin
    win_vld = m0.arvalid | m1.arvalid;
    win     = (m0.arvalid & m1.arvalid) ? ~last_grant_q : m1.arvalid;
  end

  assign in_data = (state_q == DATA);

  assign m0.arready = (state_q == IDLE) & win_vld & ~win;
  assign m1.arready = (state_q == IDLE) & win_vld &  win;

  // R path reaches only the owning master, and only while in DATA; a beat
  // presented in any other state is never acknowledged.
  assign m0.rvalid  = in_data & ~grant_q & axi.rvalid;
  assign m0.rdata   = (in_data & ~grant_q) ? axi.rdata : '0;
  assign m0.rresp   = (in_data & ~grant_q) ? axi.rresp : '0;
  assign m1.rvalid  = in_data &  grant_q & axi.rvalid;
  assign m1.rdata   = (in_data &  grant_q) ? axi.rdata : '0;
  assign m1.rresp   = (in_data &  grant_q) ? axi.rresp : '0;
  assign axi.rready = in_data & (grant_q ? m1.rready : m0.rready);

  assign axi.arvalid = arvalid_q;
  assign axi.araddr  = araddr_q;
  assign axi.arprot  = arprot_q;
  assign busy        = (state_q != IDLE);
  assign grant       = grant_q;

  // Transaction FSM with registered AR outputs and ownership tracking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      arvalid_q    <= 1'b0;
      araddr_q     <= '0;
      arprot_q     <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: if (win_vld) begin
          araddr_q  <= win ? m1.araddr : m0.araddr;
          arprot_q  <= win ? m1.arprot : m0.arprot;
          arvalid_q <= 1'b1;
          grant_q   <= win;
          state_q   <= ADDR;
        end
        ADDR: if (axi.arready) begin
          arvalid_q <= 1'b0;
          state_q   <= DATA;
        end
        DATA: if (axi.rvalid & axi.rready) begin
          last_grant_q <= grant_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
